rob: RTL and testbench
======================

# rob

Reorder buffer for the out-of-order RV32I core: a circular queue that allocates a tag per issued instruction, captures results broadcast on the CDB, and retires entries in program order. It is the producer of the register file's commit/rollback interface and the source of `issue_rdTag` for renaming. It also answers reservation-station operand queries and triggers a full flush on branch misprediction.

## Interface
- `ROB_SIZE`, 16: entry count; power of two; tag width `ROB_W` = log2(`ROB_SIZE`), 4.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `rdy` in 1: global enable; when low, no state changes and all pulse outputs are held at 0.
- `issue_valid` in 1: allocate one entry this cycle.
- `issue_type` in 2: 0 = ALU/load (writes rd), 1 = store, 2 = branch.
- `issue_rd` in 5: destination register.
- `issue_predTaken` in 1: predictor decision for a branch.
- `issue_pc` in 32: instruction PC.
- `issue_tag` out `ROB_W`: tail index, the tag the next allocation receives.
- `full` out 1: `count == ROB_SIZE`.
- `cdb_valid` in 1: result broadcast.
- `cdb_tag` in `ROB_W`, `cdb_val` in 32: producing entry and its result.
- `cdb_taken` in 1: actual branch outcome.
- `cdb_target` in 32: correct next PC for the branch.
- `query_tag1`, `query_tag2` in `ROB_W`: operand lookups.
- `query_rdy1`, `query_rdy2` out 1: entry result is available.
- `query_val1`, `query_val2` out 32: entry result value.
- `commit_valid` out 1: one-cycle retire pulse (to regFile).
- `commit_rd` out 5, `commit_tag` out `ROB_W`, `commit_val` out 32: retire payload.
- `store_commit` out 1: one-cycle pulse; the store with tag `commit_tag` may write memory.
- `rollback` out 1: one-cycle flush pulse.
- `rollback_pc` out 32: fetch redirect, valid with `rollback`.

## Operation
- State: per-entry `busy`, `ready`, `type`, `rd`, `val`, `predTaken`, `taken`, `target`; plus `head`, `tail` (`ROB_W` bits) and `count` (`ROB_W`+1 bits).
- Issue, when `issue_valid && !full && !rollback_now`:
  - write the entry at `tail` with `ready` = 0, except stores, which are written with `ready` = 1;
  - `tail` increments modulo `ROB_SIZE`.
- An `issue_valid` while `full` is ignored; the dispatcher must not do this.
- CDB: when `cdb_valid` and `busy[cdb_tag]`, set `ready` and latch `val`, `taken`, `target`.
- Commit, when `busy[head] && ready[head]`:
  - pulse `commit_valid`;
  - `commit_rd` = `rd[head]` for type 0, otherwise 0; branches and stores retire with rd = 0;
  - `commit_tag` = `head`, `commit_val` = `val[head]`;
  - for a store, also pulse `store_commit`;
  - `head` increments modulo `ROB_SIZE`.
- Misprediction: a committing branch with `taken != predTaken`:
  - pulses `rollback`, with `rollback_pc` = `target` if taken, else `pc+4`;
  - on that same edge clears every `busy` and sets `head` = `tail` = `count` = 0.
- Operand query (combinational): `query_rdyN` = `ready[tagN] || (cdb_valid && cdb_tag == tagN)`; `query_valN` uses the CDB value on a tag match, otherwise `val[tagN]`.
- `count` update: +1 on issue, -1 on commit, unchanged on both; forced to 0 on rollback.

## Timing
- Reset values: all outputs 0, `head` = `tail` = `count` = 0, every `busy` = 0.
- Issue to earliest commit: 1 cycle for a store; for others, 1 cycle after the CDB write.
- A CDB write to the current head is visible to commit on the next cycle.
- Commit outputs are registered; at most one retire per cycle.
- `rollback` and `commit_valid` (rd = 0) assert in the same cycle for the mispredicted branch.
- Same-cycle issue and commit at `full`: the issue is dropped.
- Issue in the cycle `rollback` is generated: dropped, because the flush wins.
- `rst` mid-operation discards all entries; no pulse outputs in the following cycle.

## Structure
- Constants go in `defines.v`: `ROB_SIZE`, `ROBRange` ([`ROB_W`-1:0]), type codes `TYPE_ALU`, `TYPE_STORE`, `TYPE_BRANCH`, and `True`/`False`.
- Single flat module; no sub-module is needed. Entry arrays are reg vectors indexed by tag.

## Test plan
- Issue ALU rd = 5 (tag 0), then CDB tag 0 with val 0x1234 → next cycle `commit_valid`, rd 5, tag 0, val 0x1234; `count` returns to 0.
- Issue 16 entries → `full` = 1, `issue_tag` wraps to 0; a 17th issue is ignored and `count` stays 16.
- Issue tags 0, 1, 2; CDB on tags 2 then 1 then 0 → commits in order 0, 1, 2 on consecutive cycles.
- Branch predicted not-taken, CDB with taken = 1, target 0x100 → `rollback` = 1 with `rollback_pc` 0x100; next cycle `head` = `tail` = `count` = 0 and the younger entries are discarded.
- Query tag 3 in the same cycle as CDB tag 3 val 0xAB → `query_rdy` = 1, `query_val` = 0xAB.
- Store issued → `store_commit` pulse on the next cycle with rd 0; hold `rdy` = 0 for 3 cycles beforehand → no commit until `rdy` returns.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared constants and types for the reorder buffer: sizing, tag type and
// the instruction class codes carried by each entry.
package rob_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ROB_W    = $clog2(ROB_SIZE);

  typedef logic [ROB_W-1:0] rob_tag_t;

  typedef enum logic [1:0] {
    TYPE_ALU    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2
  } rob_type_e;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

endpackage

// File: rtl/rob.sv
// Reorder buffer: circular queue allocating tags at tail, capturing CDB results,
// retiring in order from head, and flushing everything on a branch mispredict.
module rob
  import rob_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [1:0]       issue_type,
  input  logic [4:0]       issue_rd,
  input  logic             issue_predTaken,
  input  logic [31:0]      issue_pc,
  output logic [ROB_W-1:0] issue_tag,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_val,
  input  logic             cdb_taken,
  input  logic [31:0]      cdb_target,
  input  logic [ROB_W-1:0] query_tag1,
  input  logic [ROB_W-1:0] query_tag2,
  output logic             query_rdy1,
  output logic             query_rdy2,
  output logic [31:0]      query_val1,
  output logic [31:0]      query_val2,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [ROB_W-1:0] commit_tag,
  output logic [31:0]      commit_val,
  output logic             store_commit,
  output logic             rollback,
  output logic [31:0]      rollback_pc
);

  localparam logic [ROB_W:0] FULL_COUNT = (ROB_W+1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0] busy, ready, pred_taken, taken;
  rob_type_e           typ      [ROB_SIZE];
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [31:0]         val_q    [ROB_SIZE];
  logic [31:0]         target_q [ROB_SIZE];
  logic [31:0]         pc_q     [ROB_SIZE];

  rob_tag_t       head, tail;
  logic [ROB_W:0] count;

  logic commit_now, mispredict, issue_now;

  assign full      = (count == FULL_COUNT);
  assign issue_tag = tail;

  // Flush wins over a same-cycle issue; a full queue drops the issue.
  always_comb begin
    commit_now = busy[head] && ready[head];
    mispredict = commit_now && (typ[head] == TYPE_BRANCH) &&
                 (taken[head] != pred_taken[head]);
    issue_now  = issue_valid && !full && !mispredict;
  end

  // CDB bypass lets a reservation station grab a result in its broadcast cycle.
  always_comb begin
    query_rdy1 = ready[query_tag1] || (cdb_valid && cdb_tag == query_tag1);
    query_rdy2 = ready[query_tag2] || (cdb_valid && cdb_tag == query_tag2);
    query_val1 = (cdb_valid && cdb_tag == query_tag1) ? cdb_val : val_q[query_tag1];
    query_val2 = (cdb_valid && cdb_tag == query_tag2) ? cdb_val : val_q[query_tag2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      ready        <= '0;
      commit_valid <= False;
      commit_rd    <= '0;
      commit_tag   <= '0;
      commit_val   <= '0;
      store_commit <= False;
      rollback     <= False;
      rollback_pc  <= '0;
    end else if (rdy) begin
      commit_valid <= commit_now;
      store_commit <= commit_now && (typ[head] == TYPE_STORE);
      rollback     <= mispredict;
      if (commit_now) begin
        commit_rd  <= (typ[head] == TYPE_ALU) ? rd_q[head] : 5'd0;
        commit_tag <= head;
        commit_val <= val_q[head];
      end
      if (mispredict) begin
        rollback_pc <= taken[head] ? target_q[head] : pc_q[head] + 32'd4;
        busy        <= '0;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
      end else begin
        if (cdb_valid && busy[cdb_tag]) begin
          ready[cdb_tag]    <= True;
          val_q[cdb_tag]    <= cdb_val;
          taken[cdb_tag]    <= cdb_taken;
          target_q[cdb_tag] <= cdb_target;
        end
        if (commit_now) begin
          busy[head] <= False;
          head       <= head + 1'b1;
        end
        if (issue_now) begin
          busy[tail]       <= True;
          ready[tail]      <= (rob_type_e'(issue_type) == TYPE_STORE);
          typ[tail]        <= rob_type_e'(issue_type);
          rd_q[tail]       <= issue_rd;
          pc_q[tail]       <= issue_pc;
          pred_taken[tail] <= issue_predTaken;
          tail             <= tail + 1'b1;
        end
        case ({issue_now, commit_now})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end else begin
      commit_valid <= False;
      store_commit <= False;
      rollback     <= False;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: linear sequence of steps with hand-computed
// expectations checked by immediate assertions.
module tb_rob;
  import rob_pkg::*;

  logic             clk, rst, rdy;
  logic             issue_valid;
  logic [1:0]       issue_type;
  logic [4:0]       issue_rd;
  logic             issue_predTaken;
  logic [31:0]      issue_pc;
  logic [ROB_W-1:0] issue_tag;
  logic             full;
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_tag;
  logic [31:0]      cdb_val;
  logic             cdb_taken;
  logic [31:0]      cdb_target;
  logic [ROB_W-1:0] query_tag1, query_tag2;
  logic             query_rdy1, query_rdy2;
  logic [31:0]      query_val1, query_val2;
  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [ROB_W-1:0] commit_tag;
  logic [31:0]      commit_val;
  logic             store_commit, rollback;
  logic [31:0]      rollback_pc;

  int vectors = 0;
  int miscompares = 0;

  rob dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_predTaken(issue_predTaken), .issue_pc(issue_pc),
    .issue_tag(issue_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_rdy1(query_rdy1), .query_rdy2(query_rdy2),
    .query_val1(query_val1), .query_val2(query_val2),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_tag(commit_tag), .commit_val(commit_val),
    .store_commit(store_commit), .rollback(rollback), .rollback_pc(rollback_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] r,
                          input logic p, input logic [31:0] pc_i);
    issue_valid = 1'b1; issue_type = t; issue_rd = r;
    issue_predTaken = p; issue_pc = pc_i;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_cdb(input logic [ROB_W-1:0] t, input logic [31:0] v,
                        input logic tk, input logic [31:0] tgt);
    cdb_valid = 1'b1; cdb_tag = t; cdb_val = v; cdb_taken = tk; cdb_target = tgt;
    tick();
    cdb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    issue_valid = 0; issue_type = 0; issue_rd = 0; issue_predTaken = 0; issue_pc = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_val = 0; cdb_taken = 0; cdb_target = 0;
    query_tag1 = 0; query_tag2 = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_rollback", 32'(rollback), 0);
    chk("rst_store_commit", 32'(store_commit), 0);
    chk("rst_issue_tag", 32'(issue_tag), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(dut.count), 0);
    chk("rst_commit_val", commit_val, 0);

    // ALU issue, CDB, commit
    do_issue(2'd0, 5'd5, 1'b0, 32'h10);
    chk("alu_issue_tag", 32'(issue_tag), 1);
    chk("alu_count", 32'(dut.count), 1);
    do_cdb(4'd0, 32'h1234, 1'b0, 32'h0);
    chk("alu_no_early_commit", 32'(commit_valid), 0);
    tick();
    chk("alu_commit_valid", 32'(commit_valid), 1);
    chk("alu_commit_rd", 32'(commit_rd), 5);
    chk("alu_commit_tag", 32'(commit_tag), 0);
    chk("alu_commit_val", commit_val, 32'h1234);
    chk("alu_count_back", 32'(dut.count), 0);
    tick();
    chk("alu_pulse_single", 32'(commit_valid), 0);

    // Operand query with CDB bypass (entries 3 and 4 are idle)
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_val = 32'hAB;
    query_tag1 = 4'd3; query_tag2 = 4'd4;
    #1;
    chk("query_bypass_rdy", 32'(query_rdy1), 1);
    chk("query_bypass_val", query_val1, 32'hAB);
    chk("query_other_rdy", 32'(query_rdy2), 0);
    cdb_valid = 1'b0;
    tick();

    // Out-of-order results, in-order retirement (tags 1,2,3)
    do_issue(2'd0, 5'd10, 1'b0, 32'h20);
    do_issue(2'd0, 5'd11, 1'b0, 32'h24);
    do_issue(2'd0, 5'd12, 1'b0, 32'h28);
    chk("ooo_count", 32'(dut.count), 3);
    do_cdb(4'd3, 32'h33, 1'b0, 32'h0);
    chk("ooo_wait_a", 32'(commit_valid), 0);
    do_cdb(4'd2, 32'h22, 1'b0, 32'h0);
    chk("ooo_wait_b", 32'(commit_valid), 0);
    do_cdb(4'd1, 32'h11, 1'b0, 32'h0);
    chk("ooo_wait_c", 32'(commit_valid), 0);
    tick();
    chk("ooo_c1_valid", 32'(commit_valid), 1);
    chk("ooo_c1_tag", 32'(commit_tag), 1);
    chk("ooo_c1_val", commit_val, 32'h11);
    tick();
    chk("ooo_c2_tag", 32'(commit_tag), 2);
    chk("ooo_c2_rd", 32'(commit_rd), 11);
    tick();
    chk("ooo_c3_tag", 32'(commit_tag), 3);
    chk("ooo_c3_val", commit_val, 32'h33);
    tick();
    chk("ooo_drained", 32'(commit_valid), 0);
    chk("ooo_count0", 32'(dut.count), 0);

    // Store commit, stalled by rdy
    do_issue(2'd1, 5'd7, 1'b0, 32'h30);
    chk("st_no_commit_yet", 32'(commit_valid), 0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_stalled", 32'(commit_valid), 0);
    end
    chk("st_stalled_count", 32'(dut.count), 1);
    rdy = 1'b1;
    tick();
    chk("st_commit_valid", 32'(commit_valid), 1);
    chk("st_store_commit", 32'(store_commit), 1);
    chk("st_commit_rd", 32'(commit_rd), 0);
    chk("st_commit_tag", 32'(commit_tag), 4);
    tick();
    chk("st_pulse_single", 32'(store_commit), 0);

    // Mispredicted branch (pred NT, taken) with a younger entry and a same-cycle issue
    do_issue(2'd2, 5'd9, 1'b0, 32'h40);
    do_issue(2'd0, 5'd3, 1'b0, 32'h44);
    do_cdb(4'd5, 32'h0, 1'b1, 32'h100);
    issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd4; issue_pc = 32'h48;
    tick();
    issue_valid = 1'b0;
    chk("mp_rollback", 32'(rollback), 1);
    chk("mp_rollback_pc", rollback_pc, 32'h100);
    chk("mp_commit_valid", 32'(commit_valid), 1);
    chk("mp_commit_rd", 32'(commit_rd), 0);
    chk("mp_commit_tag", 32'(commit_tag), 5);
    chk("mp_count", 32'(dut.count), 0);
    chk("mp_head", 32'(dut.head), 0);
    chk("mp_tail", 32'(issue_tag), 0);
    do_cdb(4'd6, 32'h66, 1'b0, 32'h0);
    chk("mp_rollback_single", 32'(rollback), 0);
    tick();
    chk("mp_young_discarded", 32'(commit_valid), 0);

    // Mispredicted branch (pred T, not taken) -> pc+4
    do_issue(2'd2, 5'd0, 1'b1, 32'h200);
    do_cdb(4'd0, 32'h0, 1'b0, 32'h999);
    tick();
    chk("mpnt_rollback", 32'(rollback), 1);
    chk("mpnt_rollback_pc", rollback_pc, 32'h204);

    // Fill to full, overflow issue ignored
    for (int i = 0; i < 16; i++) do_issue(2'd0, 5'(i + 1), 1'b0, 32'(i * 4));
    chk("full_flag", 32'(full), 1);
    chk("full_tag_wrap", 32'(issue_tag), 0);
    chk("full_count", 32'(dut.count), 16);
    do_issue(2'd0, 5'd31, 1'b0, 32'hFC);
    chk("full_overflow_count", 32'(dut.count), 16);
    do_cdb(4'd0, 32'h5, 1'b0, 32'h0);
    issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd30;
    tick();
    issue_valid = 1'b0;
    chk("full_commit_valid", 32'(commit_valid), 1);
    chk("full_commit_val", commit_val, 32'h5);
    chk("full_issue_dropped", 32'(dut.count), 15);
    chk("full_tail_held", 32'(issue_tag), 0);

    // Reset mid-operation
    do_cdb(4'd1, 32'h77, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_count", 32'(dut.count), 0);
    tick();
    chk("mrst_no_pulse", 32'(commit_valid), 0);
    chk("mrst_tail", 32'(issue_tag), 0);

    // Correctly predicted branch: retires without rollback
    do_issue(2'd2, 5'd8, 1'b1, 32'h300);
    do_cdb(4'd0, 32'h0, 1'b1, 32'h400);
    tick();
    chk("br_ok_commit", 32'(commit_valid), 1);
    chk("br_ok_no_rollback", 32'(rollback), 0);
    chk("br_ok_rd", 32'(commit_rd), 0);
    chk("br_ok_count", 32'(dut.count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
